// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - carry-save beat accumulator with one-cycle resolve and valid/ready result port
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset; aborts any job, no result produced
//   start      job start pulse, honoured only in IDLE
//   cfg_len    beats in the job (0..255), captured with start
//   in_valid   beat valid
//   in_ready   beat accepted this cycle when high together with in_valid (ACC only)
//   in_data    five unsigned lanes, lane i = in_data[i*IN_W +: IN_W]
//   out_valid  result valid (OUT only)
//   out_ready  consumer accepts result
//   out_sum    total of all lanes over all beats, mod 2^ACC_W
//   out_ovf    true total did not fit in ACC_W bits
//   busy       high in every state except IDLE
module csa_accum_ctrl #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5*IN_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);
    localparam int LANES = 5;
    // 11 extra bits cover 5 lanes x 255 beats of worst-case input exactly.
    localparam int IW    = IN_W + 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      cnt;
    logic [IW-1:0]   acc_s;
    logic [IW-1:0]   acc_c;
    logic [IW-1:0]   nx_s;
    logic [IW-1:0]   nx_c;
    logic [IW-1:0]   result;
    logic [ACC_W-1:0] res_lo;
    logic            res_ovf;
    logic [IW-1:0]   lane [LANES];
    logic [2*IW-1:0] t0, t1, t2, t3, t4;
    logic            beat_take;

    // 3:2 compressor; returns {carry, sum}. The carry bit shifted out of the
    // top is dropped safely because the exact total always fits in IW bits.
    function automatic logic [2*IW-1:0] csa3(input logic [IW-1:0] a,
                                             input logic [IW-1:0] b,
                                             input logic [IW-1:0] c);
        logic [IW-1:0] s;
        logic [IW-1:0] cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy, s};
    endfunction

    // Seven operands (five lanes plus the redundant sum/carry pair) reduced
    // to two by a chain of five compressors; no carry-propagate in the loop.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane[i] = IW'(in_data[i*IN_W +: IN_W]);
        end
        t0   = csa3(lane[0], lane[1], lane[2]);
        t1   = csa3(lane[3], lane[4], acc_s);
        t2   = csa3(t0[IW-1:0], t0[2*IW-1:IW], t1[IW-1:0]);
        t3   = csa3(t2[IW-1:0], t2[2*IW-1:IW], t1[2*IW-1:IW]);
        t4   = csa3(t3[IW-1:0], t3[2*IW-1:IW], acc_c);
        nx_s = t4[IW-1:0];
        nx_c = t4[2*IW-1:IW];
    end

    assign result = acc_s + acc_c;

    generate
        if (ACC_W >= IW) begin : g_wide
            assign res_lo  = ACC_W'(result);
            assign res_ovf = 1'b0;
        end else begin : g_narrow
            assign res_lo  = result[ACC_W-1:0];
            assign res_ovf = |result[IW-1:ACC_W];
        end
    endgenerate

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        beat_take = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (cfg_len == 8'd0) ? RESOLVE : ACC;
                end
            end
            ACC: begin
                in_ready  = 1'b1;
                beat_take = in_valid;
                if (in_valid && cnt == 8'd1) begin
                    state_nx = RESOLVE;
                end
            end
            RESOLVE: begin
                state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            acc_s   <= '0;
            acc_c   <= '0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                cnt   <= cfg_len;
                acc_s <= '0;
                acc_c <= '0;
            end
            if (beat_take) begin
                cnt   <= cnt - 8'd1;
                acc_s <= nx_s;
                acc_c <= nx_c;
            end
            if (state == RESOLVE) begin
                out_sum <= res_lo;
                out_ovf <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - scoreboard bench for csa_accum_ctrl
module tb_csa_accum_ctrl;
    localparam int IN_W  = 8;
    localparam int ACC_W = 16;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              start     = 1'b0;
    logic [7:0]        cfg_len   = 8'd0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [5*IN_W-1:0] in_data   = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    csa_accum_ctrl #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } exp_t;

    int                checks   = 0;
    int                failures = 0;
    exp_t              exp_q[$];
    logic [5*IN_W-1:0] beats[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5*IN_W-1:0] pack(input int a, input int b, input int c,
                                               input int d, input int e);
        return {IN_W'(e), IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
    endfunction

    // Reference: plain integer sum of every lane of every queued beat.
    task automatic push_expected();
        longint            total;
        logic [5*IN_W-1:0] w;
        exp_t              e;
        total = 0;
        foreach (beats[b]) begin
            w = beats[b];
            for (int l = 0; l < 5; l++) total += longint'(w[l*IN_W +: IN_W]);
        end
        e.sum = ACC_W'(total % (longint'(1) << ACC_W));
        e.ovf = (total >= (longint'(1) << ACC_W));
        exp_q.push_back(e);
    endtask

    // Monitor: every result handshake pops one expected entry.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sum", longint'(out_sum), longint'(e.sum));
                chk("out_ovf", longint'(out_ovf), longint'(e.ovf));
            end
        end
    end

    task automatic start_job(input int len);
        cfg_len = 8'(len);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cfg_len = 8'($urandom);
        chk("busy_after_start", longint'(busy), 1);
    endtask

    task automatic feed(input int bubble_pct, input int start_at);
        int idx;
        int guard;
        bit acc;
        idx   = 0;
        guard = 0;
        while (idx < beats.size() && guard < 2000) begin
            if (int'($urandom_range(0, 99)) >= bubble_pct) begin
                in_valid = 1'b1;
                in_data  = beats[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = 40'({$urandom, $urandom});
            end
            if (idx == start_at) begin
                start   = 1'b1;
                cfg_len = 8'd200;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b0;
            if (acc) idx++;
            guard++;
        end
        if (guard >= 2000) chk("feed_timeout", 0, 1);
    endtask

    // Entered #1 after the edge that took the last beat (or the zero-length start).
    task automatic finish_job(input int stall, input bit start_in_out);
        chk("resolve_no_valid", longint'(out_valid), 0);
        chk("resolve_no_ready", longint'(in_ready), 0);
        @(posedge clk); #1;
        chk("out_valid_latency", longint'(out_valid), 1);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (stall > 0) begin
            chk("stall_valid_held", longint'(out_valid), 1);
            if (exp_q.size() > 0) chk("stall_sum_held", longint'(out_sum), longint'(exp_q[0].sum));
        end
        out_ready = 1'b1;
        if (start_in_out) begin
            start   = 1'b1;
            cfg_len = 8'd3;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk("idle_after_hs_busy", longint'(busy), 0);
        chk("idle_after_hs_valid", longint'(out_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, longint'(in_ready), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_out_sum"}, longint'(out_sum), 0);
        chk({tag, "_out_ovf"}, longint'(out_ovf), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
    endtask

    initial begin
        int len;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;

        // Single beat 1..5 -> 15
        beats = {};
        beats.push_back(pack(1, 2, 3, 4, 5));
        push_expected();
        start_job(1);
        feed(0, -1);
        finish_job(0, 1'b0);

        // Zero-length job
        beats = {};
        push_expected();
        start_job(0);
        finish_job(0, 1'b0);

        // Full-length job, all lanes at max -> wraps ACC_W, overflow set
        beats = {};
        for (int i = 0; i < 255; i++) beats.push_back(pack(255, 255, 255, 255, 255));
        push_expected();
        start_job(255);
        feed(0, -1);
        finish_job(0, 1'b0);

        // Bubbles on input, consumer stalls 10 cycles -> 60
        beats = {};
        for (int i = 0; i < 4; i++) beats.push_back(pack(1, 2, 3, 4, 5));
        push_expected();
        start_job(4);
        feed(40, -1);
        finish_job(10, 1'b0);

        // Reset mid-job discards partial sums and produces no result
        beats = {};
        for (int i = 0; i < 3; i++) beats.push_back(pack(9, 9, 9, 9, 9));
        start_job(6);
        feed(0, -1);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        reset = 1'b1;
        beats = {};
        beats.push_back(pack(2, 2, 2, 2, 2));
        push_expected();
        start_job(1);
        feed(0, -1);
        finish_job(0, 1'b0);

        // start during ACC and during the OUT handshake is ignored
        beats = {};
        for (int i = 0; i < 3; i++)
            beats.push_back(40'({$urandom, $urandom}));
        push_expected();
        start_job(3);
        feed(20, 1);
        finish_job(3, 1'b1);

        // Random jobs
        for (int j = 0; j < 15; j++) begin
            len   = int'($urandom_range(0, 10));
            beats = {};
            for (int i = 0; i < len; i++)
                beats.push_back(40'({$urandom, $urandom}));
            push_expected();
            start_job(len);
            feed(30, -1);
            finish_job(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
